// File: rtl/spu_pkg.sv
// Shared quadword geometry, FSM state type and the rounding byte average
// used by the SPU byte-average datapath.
package spu_pkg;

    localparam int unsigned QUAD_W     = 128;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned QUAD_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    // Rounded-up average: the 9-bit sum keeps the carry, so nothing saturates.
    function automatic logic [BYTE_W-1:0] avg_round(input logic [BYTE_W-1:0] a,
                                                    input logic [BYTE_W-1:0] b);
        logic [BYTE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, 1'b1};
        return sum[BYTE_W:1];
    endfunction

endpackage

// File: rtl/avg_lane_slice.sv
// One beat worth of parallel byte averagers; the sequencer time-shares it
// across the quadword.
module avg_lane_slice
    import spu_pkg::*;
#(
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic [BEAT_BYTES*BYTE_W-1:0] a_i,
    input  logic [BEAT_BYTES*BYTE_W-1:0] b_i,
    output logic [BEAT_BYTES*BYTE_W-1:0] avg_o
);

    always_comb begin
        avg_o = '0;
        for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
            avg_o[j*BYTE_W +: BYTE_W] = avg_round(a_i[j*BYTE_W +: BYTE_W],
                                                  b_i[j*BYTE_W +: BYTE_W]);
        end
    end

endmodule

// File: rtl/byte_avg_sequencer.sv
// Two-requester round-robin front end feeding a multi-beat byte-average
// engine that builds one 128-bit result per accepted request.
module byte_avg_sequencer
    import spu_pkg::*;
#(
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [QUAD_W-1:0] register_RA0,
    input  logic [QUAD_W-1:0] register_RB0,
    input  logic [QUAD_W-1:0] register_RA1,
    input  logic [QUAD_W-1:0] register_RB1,
    output logic              rt_valid,
    input  logic              rt_ready,
    output logic [QUAD_W-1:0] register_RT,
    output logic              rt_id,
    output logic              busy
);

    localparam int unsigned BEAT_W = BEAT_BYTES * BYTE_W;
    localparam int unsigned BEATS  = QUAD_BYTES / BEAT_BYTES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [QUAD_W-1:0] ra_q, ra_d;
    logic [QUAD_W-1:0] rb_q, rb_d;
    logic [QUAD_W-1:0] rt_q, rt_d;
    logic              id_q, id_d;
    logic [1:0]        grant;
    logic              gidx;
    int unsigned       beat_off;
    logic [BEAT_W-1:0] slice_a, slice_b, slice_avg;

    // The beat counter steers which lane group of the latched operands
    // reaches the single shared averager slice.
    always_comb begin
        beat_off = 32'(beat_q) * BEAT_W;
        slice_a  = ra_q[beat_off +: BEAT_W];
        slice_b  = rb_q[beat_off +: BEAT_W];
    end

    avg_lane_slice #(
        .BEAT_BYTES(BEAT_BYTES)
    ) u_slice (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .avg_o(slice_avg)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rt_d    = rt_q;
        id_d    = id_q;
        grant   = '0;
        gidx    = (req_valid == 2'b11) ? ptr_q : req_valid[1];

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant[gidx] = 1'b1;
                    ra_d        = gidx ? register_RA1 : register_RA0;
                    rb_d        = gidx ? register_RB1 : register_RB0;
                    id_d        = gidx;
                    ptr_d       = ~gidx;
                    beat_d      = '0;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                rt_d[beat_off +: BEAT_W] = slice_avg;
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rt_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            beat_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rt_q    <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rt_q    <= rt_d;
            id_q    <= id_d;
        end
    end

    // Grant is combinational from req_valid, so gate it while reset is held.
    assign req_ready   = rst_n ? grant : '0;
    assign rt_valid    = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign register_RT = rt_q;
    assign rt_id       = id_q;

endmodule

// File: doc/byte_avg_sequencer.md
BYTE_AVG_SEQUENCER -- requirements
Module: byte_avg_sequencer

Interface
REQ-001 Parameter BEAT_BYTES, default 4, is the number of byte lanes averaged per cycle; it SHALL be 1, 2, 4, 8 or 16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-requester request strobe (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 register_RA0, register_RB0  input  128 each  requester-0 operands.
REQ-007 register_RA1, register_RB1  input  128 each  requester-1 operands.
REQ-008 rt_valid  output  1  result available.
REQ-009 rt_ready  input  1  consumer accepts result.
REQ-010 register_RT  output  128  averaged quadword.
REQ-011 rt_id  output  1  requester that owns register_RT.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE only.
REQ-014 IDLE: if any req_valid is high, the arbiter SHALL assert exactly one req_ready bit combinationally; a request is accepted when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-015 Arbitration SHALL be round-robin: a priority pointer (reset 0) selects the preferred requester; the pointer SHALL move to the other requester after each accept; a lone request SHALL be granted regardless of the pointer.
REQ-016 On accept, the selected RA/RB SHALL be latched, rt_id set to the granted index, the beat counter cleared, and the FSM SHALL enter BUSY.
REQ-017 req_ready SHALL be 0 in BUSY and DONE; operand changes after accept SHALL NOT affect the result.
REQ-018 BUSY: each cycle, byte lanes k*BEAT_BYTES through k*BEAT_BYTES+BEAT_BYTES-1 (byte j = bits j*8+:8, j=0 at LSB) SHALL be averaged and written into the result register, k = beat counter, lowest bytes first.
REQ-019 Per byte: RT_j = (RA_j + RB_j + 1) >> 1, computed in 9 bits, keeping sum bits [8:1]; no overflow or saturation.
REQ-020 After 16/BEAT_BYTES BUSY cycles the FSM SHALL enter DONE; rt_valid SHALL be high exactly in DONE.
REQ-021 Latency: accept edge to rt_valid high = 16/BEAT_BYTES cycles (4 at default).
REQ-022 DONE: register_RT and rt_id SHALL hold stable until rt_valid and rt_ready are both high at a rising edge, after which the FSM SHALL enter IDLE; no accept occurs in that same cycle.
REQ-023 Requests arriving in BUSY or DONE SHALL wait (req_valid held by requester) and SHALL be arbitrated in the next IDLE cycle.
REQ-024 rt_ready while not in DONE SHALL be ignored.

Reset
REQ-025 While rst_n is low: state = IDLE, pointer = 0, beat counter = 0, register_RT = 0, rt_id = 0, rt_valid = 0, req_ready = 0, busy = 0.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL discard the operation; no rt_valid SHALL appear after release until a new accept.

Structure
REQ-027 Shared package spu_pkg SHALL hold QUAD_W = 128, BYTE_W = 8, QUAD_BYTES = 16 and the FSM state enum type.
REQ-028 The per-beat datapath SHALL be a combinational sub-module avg_lane_slice (BEAT_BYTES parallel byte averagers), instantiated once.
REQ-029 Datapath SHALL NOT be replicated 16/BEAT_BYTES times; the one slice is time-shared.

Verification
REQ-030 RA0 = all 0xFF, RB0 = all 0x01, only req_valid[0] -> req_ready = 01, rt_valid 4 cycles after accept, register_RT = all 0x80, rt_id = 0.
REQ-031 RA1 = all 0x00, RB1 = all 0x01 -> register_RT = all 0x01 (rounds up), rt_id = 1.
REQ-032 RA0 bytes 0x00..0x0F (byte0 = 0x00), RB0 bytes 0x0F..0x00 -> every byte = 0x08; checks lane order across beats.
REQ-033 Both req_valid high continuously, rt_ready = 1 -> grants alternate 0,1,0,1 starting at 0; one result per 6 cycles (accept, 4 BUSY, DONE).
REQ-034 rt_ready held low 10 cycles in DONE -> register_RT/rt_id stable, req_ready = 00 throughout; release -> IDLE next cycle.
REQ-035 rst_n low during beat 2 of BUSY -> all outputs 0 asynchronously; after release, no rt_valid until a new request is accepted.
